// File: rtl/rep3_serial_tx_if.sv
// Word handshake into the repetition-3 transmitter and its serial-side status outputs.
// The producer drives in_valid/data_in; the transmitter drives in_ready, tx_out, tx_active and done.
interface rep3_serial_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_ready;
  logic                  tx_out;
  logic                  tx_active;
  logic                  done;

  modport master (
    output in_valid,
    output data_in,
    input  in_ready,
    input  tx_out,
    input  tx_active,
    input  done
  );

  modport slave (
    input  in_valid,
    input  data_in,
    output in_ready,
    output tx_out,
    output tx_active,
    output done
  );
endinterface

// File: rtl/rep3_serial_tx.sv
// Frames a word as start/data(LSB first)/stop with every symbol held 3 cycles; first line sample the cycle after accept.
// Accepts only in IDLE (3W+7 cycle minimum period); in_valid is ignored while a frame is on the line.
module rep3_serial_tx #(
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  rep3_serial_tx_if.slave bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            rep_cnt, rep_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                  tx_q, tx_nxt;
  logic                  done_q, done_nxt;
  logic                  accept;
  logic                  rep_wrap;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign rep_wrap      = (rep_cnt == 2'd2);

  assign bus.tx_out    = tx_q;
  assign bus.tx_active = (state != IDLE);
  assign bus.done      = done_q;

  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          shift_nxt = bus.data_in;
          rep_nxt   = 2'd0;
          bit_nxt   = '0;
        end
      end
      START: begin
        rep_nxt = rep_wrap ? 2'd0 : rep_cnt + 2'd1;
        if (rep_wrap) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        rep_nxt = rep_wrap ? 2'd0 : rep_cnt + 2'd1;
        if (rep_wrap) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        rep_nxt = rep_wrap ? 2'd0 : rep_cnt + 2'd1;
        if (rep_wrap) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is decided from the next state so tx_out comes straight from a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rep_cnt   <= 2'd0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_cnt   <= rep_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      tx_q      <= tx_nxt;
      done_q    <= done_nxt;
    end
  end
endmodule

// File: doc/rep3_serial_tx.md
# rep3_serial_tx

Repetition-3 serial transmitter: accepts a parallel word through a valid/ready handshake and drives it onto a single line as a framed serial stream. Every symbol (start bit, each data bit, stop bit) is held for exactly three consecutive clock cycles. A downstream majority-of-three voter can then recover each symbol even if any single sample is corrupted. This block is the encoder/transmit end of the team's majority-vote receive path.

## Interface
Parameters:
- DATA_WIDTH, default 8, number of data bits per frame (≥1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on data_in.
- data_in  input  DATA_WIDTH  word to transmit.
- in_ready  output  1  transmitter can accept a word.
- tx_out  output  1  serial line, registered; idle level 1.
- tx_active  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse after a frame's final stop sample.

## Operation
- Frame format, in order:
  - start bit 0;
  - data bits LSB first;
  - stop bit 1.
  - Each symbol is repeated 3 cycles, so a frame occupies 3·(DATA_WIDTH+2) cycles.
- States:
  - IDLE: tx_out=1, tx_active=0, in_ready=1. An accept (in_valid && in_ready at a clock edge) captures data_in into a shift register and moves to START.
  - START: tx_out=0 for 3 cycles, then go to DATA.
  - DATA: tx_out=shift_reg[0] for 3 cycles, then shift right. After DATA_WIDTH bits, go to STOP.
  - STOP: tx_out=1 for 3 cycles, then return to IDLE with done=1 for that first IDLE cycle.
- Counters:
  - rep_cnt counts 0..2 and wraps on the third sample of each symbol.
  - bit_cnt counts 0..DATA_WIDTH-1 and advances only when rep_cnt wraps in DATA.
  - Both counters clear on entering START.
- in_ready = (state==IDLE) && !rst. in_valid outside IDLE is ignored.
- data_in is sampled only at the accept edge. Later changes have no effect on the frame in flight.
- tx_active=1 in START, DATA and STOP; 0 otherwise.

## Timing
- Cycle numbering: cycle n is the interval between edge E(n-1) and edge En. The accept happens at edge E0.
- Frame schedule relative to the accept:
  - Cycles 1–3: tx_out=0.
  - Data bit i in cycles 4+3i .. 6+3i.
  - Stop bit in cycles 3W+4 .. 3W+6, where W=DATA_WIDTH.
  - Cycle 3W+7: state IDLE, done=1, in_ready=1, tx_out=1.
- Earliest next accept is edge E(3W+7), so the minimum frame period is 3W+7 cycles. The line is high for at least one cycle between frames.
- done is high for exactly one cycle per completed frame and is never asserted for an aborted frame.
- Reset:
  - While rst=1 at an edge, the next cycle has tx_out=1, tx_active=0, done=0, state IDLE, and counters/shift register cleared.
  - in_ready=0 while rst is high.
  - Reset mid-frame aborts the frame with no done pulse.
- rst and in_valid asserted together: reset wins, and no word is accepted.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, tx_out=1, tx_active=0, done=0 throughout. After release, in_ready=1 and nothing is transmitted until a new accept.
- Single frame, W=8, data 0xA5 -> tx_out over cycles 1–30 = 000, then 111 000 111 000 000 111 000 111, then 111. tx_active=1 in cycles 1–30. done=1 only in cycle 31.
- Back-to-back, in_valid held high with 0x00 then 0xFF -> second accept at E31. tx_out=1 in cycle 31, the second start bit begins in cycle 32, and done pulses in cycles 31 and 62.
- Ignored inputs: after accepting 0x3C, toggle data_in and in_valid randomly during cycles 2–29 -> serial stream still encodes 0x3C, in_ready stays 0, and no extra frame is sent.
- Reset mid-frame: assert rst for the edge ending cycle 10 of a 0xFF frame -> cycle 11 shows tx_out=1, tx_active=0, no done pulse. The next frame after release is complete and correct.
- Voter check: feed tx_out into a 3-sample majority voter aligned to the symbol grid. Force one corrupted sample per symbol for 16 random words -> every decoded word equals the sent word.
